// File: rtl/synthesijer_mul64_arb_pkg.sv
// Shared constants for the synthesijer 64-bit multiplier arbiter: state encoding,
// operand width and the BUSY-cycle counter width.
package synthesijer_mul64_arb_pkg;

  localparam int OPW   = 64;
  localparam int CNT_W = 4;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/synthesijer_rr_pick.sv
// Combinational round-robin picker: first set request bit at or after ptr_i, wrapping.
// Zero latency; any_o is low and gidx_o is 0 when no request is set.
module synthesijer_rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] gidx_o,
  output logic             any_o
);

  int               k;
  logic [IDX_W-1:0] kk;

  // Walk from the farthest candidate back to ptr_i so the nearest hit wins.
  always_comb begin
    gidx_o = '0;
    any_o  = 1'b0;
    k      = 0;
    kk     = '0;
    for (int i = N - 1; i >= 0; i--) begin
      k = int'(ptr_i) + i;
      if (k >= N) k = k - N;
      kk = IDX_W'(k);
      if (req_i[kk]) begin
        gidx_o = kk;
        any_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/synthesijer_mul64_arbiter.sv
// Round-robin arbiter sharing one synthesijer_mul64 among NUM_REQ requesters.
// Result and one-hot done pulse LATENCY+2 cycles after grant; stalls in BUSY while mul_valid is low.
// Optional op_count/wait_max statistics under SYNTHESIJER_MUL64_ARB_STATS_EN.
module synthesijer_mul64_arbiter
  import synthesijer_mul64_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [64*NUM_REQ-1:0]  req_a,
  input  logic [64*NUM_REQ-1:0]  req_b,
  output logic [NUM_REQ-1:0]     done,
  output logic [63:0]            result,
  output logic                   busy,
  output logic [63:0]            mul_a,
  output logic [63:0]            mul_b,
  output logic                   mul_nd,
  input  logic [63:0]            mul_result,
  input  logic                   mul_valid
`ifdef SYNTHESIJER_MUL64_ARB_STATS_EN
  ,
  output logic [31:0]            op_count,
  output logic [15:0]            wait_max
`endif
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] gidx_q, gidx_d;
  logic [IDX_W-1:0] pick;
  logic             any_req;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OPW-1:0]   result_q, result_d;
  logic [OPW-1:0]   mul_a_q, mul_a_d;
  logic [OPW-1:0]   mul_b_q, mul_b_d;
  logic             nd_q, nd_d;

  synthesijer_rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i  (req),
    .ptr_i  (rr_ptr_q),
    .gidx_o (pick),
    .any_o  (any_req)
  );

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    gidx_d   = gidx_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    mul_a_d  = mul_a_q;
    mul_b_d  = mul_b_q;
    nd_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          gidx_d  = pick;
          mul_a_d = req_a[OPW*int'(pick) +: OPW];
          mul_b_d = req_b[OPW*int'(pick) +: OPW];
          cnt_d   = '0;
          nd_d    = 1'b1;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (mul_valid && (int'(cnt_q) >= LATENCY)) begin
          result_d = mul_result;
          state_d  = ST_DONE;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        // Served requester drops to lowest priority for the next arbitration.
        rr_ptr_d = (gidx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gidx_q + IDX_W'(1);
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      gidx_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      mul_a_q  <= '0;
      mul_b_q  <= '0;
      nd_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gidx_q   <= gidx_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      mul_a_q  <= mul_a_d;
      mul_b_q  <= mul_b_d;
      nd_q     <= nd_d;
    end
  end

  assign done   = (state_q == ST_DONE) ? (NUM_REQ'(1) << gidx_q) : '0;
  assign result = result_q;
  assign busy   = (state_q != ST_IDLE);
  assign mul_a  = mul_a_q;
  assign mul_b  = mul_b_q;
  assign mul_nd = nd_q;

`ifdef SYNTHESIJER_MUL64_ARB_STATS_EN
  logic [31:0] op_count_q;
  logic [15:0] wait_max_q;
  logic [15:0] wait_cnt_q [NUM_REQ];
  logic        grant_now;

  assign grant_now = (state_q == ST_IDLE) && any_req;

  // A requester's wait counts cycles with req high while it is neither granted nor being served.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_count_q <= '0;
      wait_max_q <= '0;
      for (int i = 0; i < NUM_REQ; i++) wait_cnt_q[i] <= '0;
    end else begin
      if (state_q == ST_DONE) op_count_q <= op_count_q + 32'd1;
      if (grant_now && (wait_cnt_q[pick] > wait_max_q)) wait_max_q <= wait_cnt_q[pick];
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!req[i] || (grant_now && (pick == IDX_W'(i)))) begin
          wait_cnt_q[i] <= '0;
        end else if (!(busy && (gidx_q == IDX_W'(i))) && (wait_cnt_q[i] != 16'hFFFF)) begin
          wait_cnt_q[i] <= wait_cnt_q[i] + 16'd1;
        end
      end
    end
  end

  assign op_count = op_count_q;
  assign wait_max = wait_max_q;
`endif

endmodule

// File: tb/tb_synthesijer_mul64_arbiter.sv
// Bench for synthesijer_mul64_arbiter: two instances (LATENCY 0 and 3) with an ideal multiplier model.
// Directed scenarios plus a randomized contract-following requester population against a round-robin model.
module tb_synthesijer_mul64_arbiter;

  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;
  int   sel   = 0;
  int   vecs  = 0;
  int   errs  = 0;

  logic [N-1:0]    req0 = '0, req3 = '0;
  logic [64*N-1:0] ra0 = '0, rb0 = '0, ra3 = '0, rb3 = '0;
  logic            mv0 = 1'b1, mv3 = 1'b1;
  logic [N-1:0]    done0, done3;
  logic [63:0]     res0, res3, ma0, ma3, mb0, mb3, mr0, mr3;
  logic            busy0, busy3, nd0, nd3;
`ifdef SYNTHESIJER_MUL64_ARB_STATS_EN
  logic [31:0] opc0, opc3;
  logic [15:0] wmx0, wmx3;
`endif

  // Ideal multiplier: low word of the product is the same for signed and unsigned operands.
  assign mr0 = ma0 * mb0;
  assign mr3 = ma3 * mb3;

  synthesijer_mul64_arbiter #(.NUM_REQ(N), .LATENCY(0)) dut0 (
    .clk(clk), .reset(reset), .req(req0), .req_a(ra0), .req_b(rb0),
    .done(done0), .result(res0), .busy(busy0), .mul_a(ma0), .mul_b(mb0),
    .mul_nd(nd0), .mul_result(mr0), .mul_valid(mv0)
`ifdef SYNTHESIJER_MUL64_ARB_STATS_EN
    , .op_count(opc0), .wait_max(wmx0)
`endif
  );

  synthesijer_mul64_arbiter #(.NUM_REQ(N), .LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .req(req3), .req_a(ra3), .req_b(rb3),
    .done(done3), .result(res3), .busy(busy3), .mul_a(ma3), .mul_b(mb3),
    .mul_nd(nd3), .mul_result(mr3), .mul_valid(mv3)
`ifdef SYNTHESIJER_MUL64_ARB_STATS_EN
    , .op_count(opc3), .wait_max(wmx3)
`endif
  );

  logic [N-1:0] o_done, o_req;
  logic [63:0]  o_res, o_ma, o_mb;
  logic         o_busy, o_nd;
  assign o_done = (sel != 0) ? done3 : done0;
  assign o_res  = (sel != 0) ? res3  : res0;
  assign o_ma   = (sel != 0) ? ma3   : ma0;
  assign o_mb   = (sel != 0) ? mb3   : mb0;
  assign o_busy = (sel != 0) ? busy3 : busy0;
  assign o_nd   = (sel != 0) ? nd3   : nd0;
  assign o_req  = (sel != 0) ? req3  : req0;

  function automatic logic [63:0] prod(input logic [63:0] a, input logic [63:0] b);
    longint sa, sb;
    sa = a;
    sb = b;
    return 64'(sa * sb);
  endfunction

  function automatic int rr_next(input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++) if (r[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  task automatic cyc;
    @(negedge clk);
  endtask

  task automatic set_req(input int r, input logic v);
    if (sel != 0) req3[r] = v; else req0[r] = v;
  endtask

  task automatic set_ops(input int r, input logic [63:0] a, input logic [63:0] b);
    if (sel != 0) begin ra3[64*r +: 64] = a; rb3[64*r +: 64] = b; end
    else begin ra0[64*r +: 64] = a; rb0[64*r +: 64] = b; end
  endtask

  task automatic set_valid(input logic v);
    if (sel != 0) mv3 = v; else mv0 = v;
  endtask

  task automatic do_reset;
    cyc;
    reset = 1'b1;
    req0 = '0; req3 = '0; mv0 = 1'b1; mv3 = 1'b1;
    cyc;
    cyc;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    for (int s = 0; s < 2; s++) begin
      sel = s;
      #1;
      vecs++; if (o_done !== '0) begin errs++; $display("FAIL reset_done[%0d]: got %b want 0", s, o_done); end
      vecs++; if (o_res !== '0) begin errs++; $display("FAIL reset_result[%0d]: got %h want 0", s, o_res); end
      vecs++; if (o_busy !== 1'b0) begin errs++; $display("FAIL reset_busy[%0d]: got %b want 0", s, o_busy); end
      vecs++; if (o_nd !== 1'b0 || o_ma !== '0 || o_mb !== '0) begin
        errs++; $display("FAIL reset_mul[%0d]: got nd=%b a=%h b=%h want all 0", s, o_nd, o_ma, o_mb);
      end
    end
  endtask

  task automatic test_single;
    sel = 0;
    do_reset;
    set_ops(1, 64'd7, -64'sd3);
    set_req(1, 1'b1);
    cyc;
    vecs++; if (o_nd !== 1'b1 || o_busy !== 1'b1 || o_done !== '0) begin
      errs++; $display("FAIL single_t1: got nd=%b busy=%b done=%b want 1 1 0000", o_nd, o_busy, o_done);
    end
    cyc;
    vecs++; if (o_done !== 4'b0010) begin errs++; $display("FAIL single_done: got %b want 0010", o_done); end
    vecs++; if (o_res !== 64'hFFFF_FFFF_FFFF_FFEB) begin errs++; $display("FAIL single_result: got %h want -21", o_res); end
    vecs++; if (o_nd !== 1'b0) begin errs++; $display("FAIL single_nd_once: got %b want 0", o_nd); end
    cyc;
    set_req(1, 1'b0);
    vecs++; if (o_busy !== 1'b0 || o_done !== '0) begin
      errs++; $display("FAIL single_t3: got busy=%b done=%b want 0 0000", o_busy, o_done);
    end
  endtask

  task automatic test_latency3;
    logic [63:0] a;
    sel = 1;
    do_reset;
    a = 64'h0000_0001_0000_0000;
    set_ops(0, a, a);
    set_req(0, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      cyc;
      vecs++; if (o_busy !== 1'b1 || o_nd !== (k == 1) || o_ma !== a || o_mb !== a || o_done !== '0) begin
        errs++; $display("FAIL lat3_busy%0d: got busy=%b nd=%b a=%h b=%h done=%b want 1 %0d %h %h 0000",
                         k, o_busy, o_nd, o_ma, o_mb, o_done, (k == 1), a, a);
      end
    end
    cyc;
    vecs++; if (o_done !== 4'b0001 || o_res !== '0) begin
      errs++; $display("FAIL lat3_done: got done=%b result=%h want 0001 0", o_done, o_res);
    end
    cyc;
    set_req(0, 1'b0);
    vecs++; if (o_done !== '0) begin errs++; $display("FAIL lat3_done_width: got %b want 0000", o_done); end
  endtask

  task automatic test_round_robin;
    logic [63:0] pa [N];
    logic [63:0] pb [N];
    int k, prev, drop, last;
    sel = 0;
    do_reset;
    for (int r = 0; r < N; r++) begin
      pa[r] = {$urandom, $urandom};
      pb[r] = {$urandom, $urandom};
      set_ops(r, pa[r], pb[r]);
      set_req(r, 1'b1);
    end
    k = 0; prev = 0; drop = -1; last = -10;
    for (int c = 1; c <= 40 && k < N; c++) begin
      cyc;
      if (drop >= 0) begin set_req(drop, 1'b0); drop = -1; end
      if (last == c - 1) begin
        vecs++; if (o_done !== '0) begin errs++; $display("FAIL rr_pulse_width: got %b want 0000", o_done); end
      end
      if (o_done !== '0) begin
        vecs++; if (o_done !== (4'b0001 << k)) begin errs++; $display("FAIL rr_order%0d: got %b want %b", k, o_done, 4'b0001 << k); end
        vecs++; if (o_res !== prod(pa[k], pb[k])) begin errs++; $display("FAIL rr_result%0d: got %h want %h", k, o_res, prod(pa[k], pb[k])); end
        vecs++; if (c - prev !== ((k == 0) ? 2 : 3)) begin
          errs++; $display("FAIL rr_spacing%0d: got %0d want %0d", k, c - prev, (k == 0) ? 2 : 3);
        end
        prev = c; last = c; drop = k; k++;
      end
    end
    cyc;
    if (drop >= 0) set_req(drop, 1'b0);
    vecs++; if (k != N) begin errs++; $display("FAIL rr_timeout: got %0d completions want %0d", k, N); end
  endtask

  task automatic test_stall;
    logic [63:0] a, b;
    sel = 0;
    do_reset;
    a = 64'hFFFF_FFFF_FFFF_FFF0;
    b = 64'd1234567;
    set_ops(2, a, b);
    set_req(2, 1'b1);
    set_valid(1'b0);
    for (int k = 1; k <= 10; k++) begin
      cyc;
      vecs++; if (o_busy !== 1'b1 || o_done !== '0) begin
        errs++; $display("FAIL stall_hold%0d: got busy=%b done=%b want 1 0000", k, o_busy, o_done);
      end
    end
    set_valid(1'b1);
    cyc;
    vecs++; if (o_done !== 4'b0100 || o_res !== prod(a, b)) begin
      errs++; $display("FAIL stall_done: got done=%b result=%h want 0100 %h", o_done, o_res, prod(a, b));
    end
    cyc;
    set_req(2, 1'b0);
  endtask

  task automatic test_reset_busy;
    logic [63:0] a0, b0, a3, b3;
    sel = 0;
    do_reset;
    a0 = 64'd11; b0 = 64'd13;
    a3 = 64'h1234_5678_9ABC_DEF0; b3 = 64'd5;
    set_ops(3, a3, b3);
    set_req(3, 1'b1);
    cyc;
    vecs++; if (o_busy !== 1'b1 || o_ma !== a3) begin
      errs++; $display("FAIL rb_busy: got busy=%b a=%h want 1 %h", o_busy, o_ma, a3);
    end
    reset = 1'b1;
    cyc;
    reset = 1'b0;
    vecs++; if (o_busy !== 1'b0 || o_done !== '0 || o_nd !== 1'b0 || o_ma !== '0 || o_mb !== '0 || o_res !== '0) begin
      errs++; $display("FAIL rb_cleared: got busy=%b done=%b nd=%b a=%h b=%h res=%h want all 0",
                       o_busy, o_done, o_nd, o_ma, o_mb, o_res);
    end
    set_ops(0, a0, b0);
    set_req(0, 1'b1);
    cyc;
    vecs++; if (o_nd !== 1'b1 || o_ma !== a0 || o_done !== '0) begin
      errs++; $display("FAIL rb_grant0: got nd=%b a=%h done=%b want 1 %h 0000", o_nd, o_ma, o_done, a0);
    end
    cyc;
    vecs++; if (o_done !== 4'b0001 || o_res !== 64'd143) begin
      errs++; $display("FAIL rb_done0: got done=%b result=%h want 0001 8f", o_done, o_res);
    end
    cyc;
    set_req(0, 1'b0);
    cyc;
    cyc;
    vecs++; if (o_done !== 4'b1000 || o_res !== prod(a3, b3)) begin
      errs++; $display("FAIL rb_done3: got done=%b result=%h want 1000 %h", o_done, o_res, prod(a3, b3));
    end
    cyc;
    set_req(3, 1'b0);
  endtask

  task automatic test_random(input int s, input int ncyc);
    logic [63:0]  pa [N];
    logic [63:0]  pb [N];
    bit           pend [N];
    logic [N-1:0] prev_req;
    int ptr, exp_g, nd_c, drop, lat, served, c;
    sel = s;
    lat = (s != 0) ? 3 : 0;
    do_reset;
    for (int r = 0; r < N; r++) pend[r] = 1'b0;
    ptr = 0; exp_g = -1; nd_c = -100; drop = -1; served = 0; c = 0;
    prev_req = '0;
    while (c < ncyc + 200) begin
      cyc;
      c++;
      if (drop >= 0) begin set_req(drop, 1'b0); pend[drop] = 1'b0; end
      if (o_nd === 1'b1) begin
        exp_g = rr_next(prev_req, ptr);
        nd_c = c;
        vecs++; if (exp_g < 0) begin errs++; $display("FAIL rand_grant_without_req: got nd=1 want no strobe"); end
      end
      if (o_done !== '0) begin
        vecs++;
        if (exp_g < 0 || o_done !== (4'b0001 << exp_g) || c != nd_c + lat + 1) begin
          errs++; $display("FAIL rand_done_l%0d: got done=%b at +%0d want grant %0d at +%0d", lat, o_done, c - nd_c, exp_g, lat + 1);
        end else begin
          vecs++; if (o_res !== prod(pa[exp_g], pb[exp_g])) begin
            errs++; $display("FAIL rand_result_l%0d: got %h want %h", lat, o_res, prod(pa[exp_g], pb[exp_g]));
          end
          ptr = (exp_g + 1) % N;
        end
        drop = (exp_g >= 0) ? exp_g : -1;
        exp_g = -1;
        served++;
      end else begin
        drop = -1;
      end
      if (c < ncyc) begin
        for (int r = 0; r < N; r++) begin
          if (!pend[r] && $urandom_range(0, 2) == 0) begin
            pa[r] = ($urandom_range(0, 1) == 1) ? {$urandom, $urandom} : 64'($signed($urandom_range(0, 200)) - 100);
            pb[r] = {$urandom, $urandom};
            set_ops(r, pa[r], pb[r]);
            set_req(r, 1'b1);
            pend[r] = 1'b1;
          end
        end
      end else if (!(pend[0] || pend[1] || pend[2] || pend[3]) && drop < 0) begin
        break;
      end
      #1;
      prev_req = o_req;
    end
    vecs++; if (pend[0] || pend[1] || pend[2] || pend[3]) begin
      errs++; $display("FAIL rand_drain_l%0d: got pending %b%b%b%b want none", lat, pend[3], pend[2], pend[1], pend[0]);
    end
    vecs++; if (served < 10) begin errs++; $display("FAIL rand_throughput_l%0d: got %0d ops want >=10", lat, served); end
  endtask

`ifdef SYNTHESIJER_MUL64_ARB_STATS_EN
  task automatic test_stats;
    int drop, n;
    sel = 0;
    do_reset;
    vecs++; if (opc0 !== 32'd0 || wmx0 !== 16'd0) begin
      errs++; $display("FAIL stats_reset: got op_count=%0d wait_max=%0d want 0 0", opc0, wmx0);
    end
    for (int r = 0; r < 3; r++) begin
      set_ops(r, 64'(r + 2), 64'd3);
      set_req(r, 1'b1);
    end
    drop = -1; n = 0;
    for (int c = 0; c < 30 && n < 3; c++) begin
      cyc;
      if (drop >= 0) begin set_req(drop, 1'b0); drop = -1; end
      for (int r = 0; r < 3; r++) if (o_done[r]) begin drop = r; n++; end
    end
    cyc;
    if (drop >= 0) set_req(drop, 1'b0);
    cyc;
    // Requester 2 sits behind two full LATENCY+3 operations.
    vecs++; if (opc0 !== 32'd3) begin errs++; $display("FAIL stats_op_count: got %0d want 3", opc0); end
    vecs++; if (wmx0 !== 16'd6) begin errs++; $display("FAIL stats_wait_max: got %0d want 6", wmx0); end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_single;
    test_latency3;
    test_round_robin;
    test_stall;
    test_reset_busy;
    test_random(0, 400);
    test_random(1, 400);
`ifdef SYNTHESIJER_MUL64_ARB_STATS_EN
    test_stats;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/synthesijer_mul64_arbiter.md
# synthesijer_mul64_arbiter

Shares one `synthesijer_mul64` instance among `NUM_REQ` requesters. Grants are round-robin. The block drives the multiplier operands and `nd`, waits a configurable latency, then returns the 64-bit result to the granted requester with a one-cycle `done` pulse. It sits between the generated method FSMs and a single multiplier instance, so designs with several multiply sites need only one wide multiplier.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..16.
- `LATENCY`, 0: multiplier latency in cycles, 0..15. The result is sampled this many cycles after the `mul_nd` cycle.

Ports (vectors flattened, requester i occupies slice i):
- `clk`  in  1  sole clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  NUM_REQ  level request, one bit per requester.
- `req_a`  in  64*NUM_REQ  signed operand a per requester.
- `req_b`  in  64*NUM_REQ  signed operand b per requester.
- `done`  out  NUM_REQ  one-hot, one-cycle completion pulse.
- `result`  out  64  signed product low word; valid while `done` is nonzero.
- `busy`  out  1  high while an operation is in flight (BUSY or DONE state).
- `mul_a`  out  64  operand a to the multiplier.
- `mul_b`  out  64  operand b to the multiplier.
- `mul_nd`  out  1  new-data strobe to the multiplier.
- `mul_result`  in  64  multiplier result.
- `mul_valid`  in  1  multiplier result valid.

## Operation
- FSM states: IDLE, BUSY, DONE.
- **IDLE**
  - If any `req` bit is set, pick the first set bit at or after `rr_ptr`, wrapping modulo `NUM_REQ`.
  - Register the grant index `gidx` and latch `req_a[gidx]` / `req_b[gidx]` into `mul_a` / `mul_b`.
  - Clear `cnt` and go to BUSY.
  - If no `req` bit is set, stay in IDLE.
- **BUSY**
  - `mul_nd` is 1 on the first BUSY cycle only. `mul_a` / `mul_b` hold stable for the whole of BUSY.
  - If `cnt` ≥ `LATENCY` and `mul_valid` = 1: register `mul_result` into `result` and go to DONE.
  - Otherwise increment `cnt`, saturating at 15, and stay in BUSY.
  - If `mul_valid` stays low, the arbiter stays in BUSY indefinitely.
- **DONE**
  - `done[gidx]` = 1 for exactly one cycle.
  - `rr_ptr` ← (`gidx`+1) mod `NUM_REQ`.
  - Go to IDLE.
- Requester contract:
  - Hold `req` and operands stable until `done` is seen.
  - Deassert `req` in the cycle after `done`. That cycle is IDLE, and the requester has already lost priority through the `rr_ptr` advance.
- A `req` drop during BUSY does not abort the operation. The result is still delivered and `done` still pulses.
- Requests arriving while busy wait; no request is lost while `req` is held.
- Arithmetic: the result is the low 64 bits of the signed 128-bit product. No overflow flag.
- Reset values:
  - state IDLE, `rr_ptr` 0, `gidx` 0, `cnt` 0.
  - `done` 0, `result` 0, `busy` 0.
  - `mul_a` 0, `mul_b` 0, `mul_nd` 0.
- Reset in any state returns to IDLE on the next edge. An in-flight operation is discarded with no `done` pulse.

## Timing
- `req` sampled high in IDLE at cycle t:
  - `mul_nd` high at t+1.
  - Result captured at the edge ending cycle t+1+`LATENCY` (given `mul_valid`).
  - `done` and `result` valid in cycle t+2+`LATENCY`.
- Minimum occupancy per operation: `LATENCY`+3 cycles, including the IDLE arbitration cycle.
- Back-to-back: the next grant is sampled in the IDLE cycle immediately after DONE.
- Simultaneous requests are served strictly round-robin from `rr_ptr`. No requester waits longer than `NUM_REQ`-1 other operations.

## Configuration
- Macro `SYNTHESIJER_MUL64_ARB_STATS_EN`.
- Defined:
  - Adds output `op_count` (32 bits, reset 0).
  - Increments in every DONE cycle and wraps from 0xFFFFFFFF to 0.
  - Adds output `wait_max` (16 bits, reset 0): the longest IDLE-to-grant wait seen by any requester, in cycles, saturating.
- Undefined: neither port exists and no counters are synthesized. Core behaviour is identical.

## Structure
- Shared package `synthesijer_mul64_arb_pkg`:
  - state encoding constants (IDLE=0, BUSY=1, DONE=2).
  - operand width constant 64.
  - `CNT_W` = 4.
- One sub-module `synthesijer_rr_pick`:
  - combinational round-robin picker.
  - inputs: request vector, pointer.
  - outputs: grant index and any-request flag.
  - reused by other arbiters.

## Test plan
- Single request, `LATENCY`=0, requester 1, a=7, b=-3: `mul_nd` pulses at t+1; `done`=4'b0010 and `result`=-21 at t+2; `busy` low at t+3.
- `LATENCY`=3, a=0x1_0000_0000, b=0x1_0000_0000: `result`=0 (low word of 2^64); `done` at t+5; `mul_a`/`mul_b` stable for all 4 BUSY cycles.
- All four requesters request at once from reset: grant order 0,1,2,3; each `done` is exactly one cycle; spacing is `LATENCY`+3 cycles.
- Hold `mul_valid` low for 10 cycles with `LATENCY`=0: arbiter stays in BUSY; `done` arrives 1 cycle after `mul_valid` rises.
- Assert `reset` in the middle of BUSY: next cycle shows IDLE with all outputs at reset values and no `done` pulse; a new request then grants requester 0 first.
- With the macro defined, run 3 operations: `op_count`=3; `wait_max` equals the longest measured grant wait.
